decoder_hs: RTL and testbench
=============================

Name: decoder_hs

Overview:
- Registered, handshaked index-to-one-hot decoder. Successor to the combinational no-valid decoder.
- Adds valid/ready flow control on both sides, one output pipeline stage, and non-power-of-2 `NUM_WIRE` support with out-of-range detection.
- Adds a selectable accumulate mode that builds a running bit mask (allocation/scoreboard style).
- Sits between an index producer (issue/alloc logic) and a mask consumer (scoreboard, write-enable fan-out).

Parameters:
- `NUM_WIRE`, 4, number of output wires; must be ≥ 2. Need not be a power of 2.
- `ACCUM`, 0, 0 = pulse mode (one-hot per transaction); 1 = accumulate mode (OR new bit into held mask).
- `IDX_W`, `$clog2(NUM_WIRE)`, index width. Localparam, derived, not overridable.

Ports:
- `clk_i`, in, 1, clock; all state updates on rising edge.
- `arst_ni`, in, 1, asynchronous active-low reset.
- `clear_i`, in, 1, synchronous clear of mask and sticky state.
- `index_i`, in, `IDX_W`, index to decode.
- `index_valid_i`, in, 1, `index_i` valid.
- `index_ready_o`, out, 1, block can accept an index this cycle.
- `wire_o`, out, `NUM_WIRE`, decoded one-hot (pulse mode) or accumulated mask (accum mode).
- `wire_valid_o`, out, 1, `wire_o` holds an unconsumed update.
- `wire_ready_i`, in, 1, consumer accepts the update.
- `oor_o`, out, 1, out-of-range index flag.

Behaviour:
- **Reset (`arst_ni`=0, asynchronous):** `wire_o`='0, `wire_valid_o`=0, `oor_o`=0. `index_ready_o`=1 immediately after reset is released.
- **Ready rule:** `index_ready_o` = ~`wire_valid_o` | `wire_ready_i`. Combinational, single stage, full throughput.
- **Transfers:**
  - Input transfer (`in_xfer`) = `index_valid_i` & `index_ready_o`.
  - Output transfer (`out_xfer`) = `wire_valid_o` & `wire_ready_i`.
- **Latency:** 1 cycle. The result of `in_xfer` at edge N is visible at N+1 with `wire_valid_o`=1.
- **Decode:** `onehot` = bit `index_i` set if `index_i` < `NUM_WIRE`, else '0.
- **Out-of-range:** `index_i` ≥ `NUM_WIRE`. Only possible when `NUM_WIRE` is not a power of 2.
  - The transfer is still accepted and `wire_valid_o` is still set.
  - In pulse mode the loaded value is '0; in accum mode the mask is unchanged.
  - `oor_o` follows the Optional Feature rules.
- **Pulse mode (`ACCUM`=0):**
  - `in_xfer` → `wire_o` <= `onehot`, `wire_valid_o` <= 1.
  - `out_xfer` without `in_xfer` → `wire_o` <= '0, `wire_valid_o` <= 0.
  - `out_xfer` and `in_xfer` in the same cycle → load new value, valid stays 1.
- **Accum mode (`ACCUM`=1):**
  - `wire_o` is the persistent mask. It is never cleared by `out_xfer`, only by `clear_i` or reset.
  - `in_xfer` → mask <= mask | `onehot`, `wire_valid_o` <= 1.
  - `out_xfer` without `in_xfer` → `wire_valid_o` <= 0, mask held.
  - Re-setting an already-set bit is a legal update: `wire_valid_o` still goes to 1.
- **`clear_i`:** priority below reset, above everything else.
  - `clear_i` alone → `wire_o` <= '0, `wire_valid_o` <= 0, `oor_o` <= 0.
  - `clear_i` with `in_xfer` in the same cycle → the new transfer lands on a cleared state. Accum: mask <= `onehot`, `wire_valid_o` <= 1.
  - `clear_i` does not gate `index_ready_o`.
- **Back-pressure:** while `wire_valid_o`=1 and `wire_ready_i`=0, `wire_o`, `wire_valid_o` and `oor_o` hold stable. `index_ready_o`=0.
- **Mid-operation reset:** all state returns to reset values asynchronously. A pending update is discarded.
- **Simulation check:** `$fatal` if `NUM_WIRE` < 2.

Optional Feature:
- Macro: `DECODER_HS_OOR_STICKY_EN`.
- **Defined:**
  - `oor_o` is sticky. It sets at the edge of any out-of-range `in_xfer`.
  - It clears only on `clear_i` or reset, independent of the output handshake.
- **Undefined:**
  - `oor_o` is per-transaction. It is loaded with the out-of-range status on each `in_xfer` and qualified by `wire_valid_o`.
  - It returns to 0 with `wire_valid_o` on `out_xfer` without `in_xfer`.

Test Plan:
1. **Pulse basic:** `NUM_WIRE`=4, `ACCUM`=0, `wire_ready_i`=1; send `index_i`=2 → next cycle `wire_o`=4'b0100, `wire_valid_o`=1. Following idle cycle → `wire_o`=0, `wire_valid_o`=0.
2. **Back-pressure:** `wire_ready_i`=0; send 1 then attempt 3 → `wire_o` holds 4'b0010, `index_ready_o`=0, index 3 not accepted. Raise `wire_ready_i` → 3 is accepted, and `wire_o`=4'b1000 the cycle after.
3. **Streaming:** `wire_ready_i`=1; indices 0,1,2,3 on consecutive cycles → `wire_o` = 0001, 0010, 0100, 1000 on consecutive cycles, with no bubbles.
4. **Accum with clear:** `ACCUM`=1; send 0, 3, 3 → `wire_o`=4'b1001 with 3 valid updates. `clear_i` together with index 1 → `wire_o`=4'b0010.
5. **Out-of-range:** `NUM_WIRE`=5, index 6 → `wire_valid_o`=1, `wire_o`=0 in pulse mode, `oor_o`=1. Next valid index 4 →
   - macro off: `oor_o`=0, `wire_o`=5'b10000;
   - macro on: `oor_o` stays 1 until `clear_i`.
6. **Reset mid-transfer:** with `wire_valid_o`=1 and `wire_ready_i`=0, assert `arst_ni`=0 asynchronously → `wire_o`=0, `wire_valid_o`=0, `oor_o`=0 before the next clock edge.

Source files
------------

// File: rtl/decoder_hs.sv
// Registered valid/ready index-to-one-hot decoder with optional accumulate mode.
// Build option: DECODER_HS_OOR_STICKY_EN makes oor_o sticky until clear_i or reset.
module decoder_hs #(
   parameter int NUM_WIRE = 4,
   parameter int ACCUM    = 0,
   localparam int IDX_W   = $clog2(NUM_WIRE)
) (
   input  logic                clk_i,
   input  logic                arst_ni,
   input  logic                clear_i,
   input  logic [IDX_W-1:0]    index_i,
   input  logic                index_valid_i,
   output logic                index_ready_o,
   output logic [NUM_WIRE-1:0] wire_o,
   output logic                wire_valid_o,
   input  logic                wire_ready_i,
   output logic                oor_o
);

   if (NUM_WIRE < 2) begin : g_bad_num_wire
      $fatal(1, "decoder_hs: NUM_WIRE must be at least 2");
   end

   // One extra bit so the range compare is meaningful for power-of-2 sizes too
   localparam logic [IDX_W:0] LIMIT = (IDX_W+1)'(NUM_WIRE);

   logic [NUM_WIRE-1:0] wire_q, wire_d;
   logic                valid_q, valid_d;
   logic                oor_q, oor_d;
   logic [NUM_WIRE-1:0] onehot;
   logic                oor_in;
   logic                in_xfer;
   logic                out_xfer;

   assign index_ready_o = ~valid_q | wire_ready_i;
   assign in_xfer       = index_valid_i & index_ready_o;
   assign out_xfer      = valid_q & wire_ready_i;
   assign oor_in        = {1'b0, index_i} >= LIMIT;

   always_comb begin
      onehot = '0;
      for (int i = 0; i < NUM_WIRE; i++) begin
         onehot[i] = (int'(index_i) == i);
      end
   end

   always_comb begin
      wire_d  = wire_q;
      valid_d = valid_q;
      oor_d   = oor_q;
      if (clear_i) begin
         wire_d  = '0;
         valid_d = 1'b0;
         oor_d   = 1'b0;
      end
      if (in_xfer) begin
         valid_d = 1'b1;
         wire_d  = (ACCUM != 0) ? (wire_d | onehot) : onehot;
`ifdef DECODER_HS_OOR_STICKY_EN
         oor_d   = oor_d | oor_in;
`else
         oor_d   = oor_in;
`endif
      end else if (out_xfer) begin
         valid_d = 1'b0;
         if (ACCUM == 0) begin
            wire_d = '0;
         end
`ifndef DECODER_HS_OOR_STICKY_EN
         oor_d   = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         wire_q  <= '0;
         valid_q <= 1'b0;
         oor_q   <= 1'b0;
      end else begin
         wire_q  <= wire_d;
         valid_q <= valid_d;
         oor_q   <= oor_d;
      end
   end

   assign wire_o       = wire_q;
   assign wire_valid_o = valid_q;
   assign oor_o        = oor_q;

endmodule

// File: tb/tb_decoder_hs.sv
// Scoreboard bench for decoder_hs: pulse and accumulate instances (NUM_WIRE=5) share one stimulus stream.
module tb_decoder_hs;
   localparam int NW = 5;
   localparam int IW = 3;
`ifdef DECODER_HS_OOR_STICKY_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          arst_n;
   logic          clear;
   logic          index_valid;
   logic          wire_ready;
   logic [IW-1:0] index;
   logic          rdy_p, rdy_a, val_p, val_a, oor_p, oor_a;
   logic [NW-1:0] w_p, w_a;

   decoder_hs #(.NUM_WIRE(NW), .ACCUM(0)) u_pulse (
      .clk_i(clk), .arst_ni(arst_n), .clear_i(clear), .index_i(index),
      .index_valid_i(index_valid), .index_ready_o(rdy_p), .wire_o(w_p),
      .wire_valid_o(val_p), .wire_ready_i(wire_ready), .oor_o(oor_p));

   decoder_hs #(.NUM_WIRE(NW), .ACCUM(1)) u_accum (
      .clk_i(clk), .arst_ni(arst_n), .clear_i(clear), .index_i(index),
      .index_valid_i(index_valid), .index_ready_o(rdy_a), .wire_o(w_a),
      .wire_valid_o(val_a), .wire_ready_i(wire_ready), .oor_o(oor_a));

   int checks = 0;
   int errors = 0;

   // expected updates {oor, mask}, pushed at acceptance, popped at consumption
   logic [NW:0] qp[$];
   logic [NW:0] qa[$];

   // reference state: what each block should hold after the most recent edge
   bit            m_valid, m_oor;
   logic [NW-1:0] m_pulse, m_acc;
   bit            vis_valid, vis_oor;
   logic [NW-1:0] vis_pulse, vis_acc;
   bit            mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_oor   = 1'b0;
      m_pulse = '0;
      m_acc   = '0;
      qp.delete();
      qa.delete();
   endtask

   // Drive one cycle of inputs and advance the reference model across the next edge
   task automatic step(input bit clr, input bit v, input logic [IW-1:0] idx, input bit rdy);
      bit            old_valid, accept, out_of_range;
      logic [NW-1:0] bitv;
      @(posedge clk);
      #1;
      vis_valid = m_valid;
      vis_oor   = m_oor;
      vis_pulse = m_pulse;
      vis_acc   = m_acc;
      mon_en    = 1'b1;
      clear       = clr;
      index_valid = v;
      index       = idx;
      wire_ready  = rdy;

      old_valid    = m_valid;
      accept       = v && (!old_valid || rdy);
      out_of_range = (int'(idx) >= NW);
      bitv         = out_of_range ? '0 : (NW'(1) << idx);
      if (clr && old_valid && !rdy) begin
         if (qp.size() > 0) void'(qp.pop_front());
         if (qa.size() > 0) void'(qa.pop_front());
      end
      if (clr) begin
         m_valid = 1'b0;
         m_oor   = 1'b0;
         m_pulse = '0;
         m_acc   = '0;
      end
      if (accept) begin
         m_valid = 1'b1;
         m_pulse = bitv;
         m_acc   = m_acc | bitv;
         m_oor   = STICKY ? (m_oor | out_of_range) : out_of_range;
         qp.push_back({m_oor, m_pulse});
         qa.push_back({m_oor, m_acc});
      end else if (old_valid && rdy) begin
         m_valid = 1'b0;
         m_pulse = '0;
         if (!STICKY) m_oor = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         chk("ready_pulse", 32'(rdy_p), 32'(!vis_valid || wire_ready));
         chk("ready_accum", 32'(rdy_a), 32'(!vis_valid || wire_ready));
         chk("valid_pulse", 32'(val_p), 32'(vis_valid));
         chk("valid_accum", 32'(val_a), 32'(vis_valid));
         chk("wire_pulse",  32'(w_p),   32'(vis_pulse));
         chk("wire_accum",  32'(w_a),   32'(vis_acc));
         chk("oor_pulse",   32'(oor_p), 32'(vis_oor));
         chk("oor_accum",   32'(oor_a), 32'(vis_oor));
         if (val_p && wire_ready) begin
            if (qp.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_pulse: update %0h presented with no expected entry", {oor_p, w_p});
            end else begin
               chk("sb_pulse", 32'({oor_p, w_p}), 32'(qp.pop_front()));
            end
         end
         if (val_a && wire_ready) begin
            if (qa.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_accum: update %0h presented with no expected entry", {oor_a, w_a});
            end else begin
               chk("sb_accum", 32'({oor_a, w_a}), 32'(qa.pop_front()));
            end
         end
      end
   end

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_wire_p"},  32'(w_p),   32'd0);
      chk({tag, "_wire_a"},  32'(w_a),   32'd0);
      chk({tag, "_valid_p"}, 32'(val_p), 32'd0);
      chk({tag, "_valid_a"}, 32'(val_a), 32'd0);
      chk({tag, "_oor_p"},   32'(oor_p), 32'd0);
      chk({tag, "_oor_a"},   32'(oor_a), 32'd0);
   endtask

   initial begin
      clear       = 1'b0;
      index_valid = 1'b0;
      index       = '0;
      wire_ready  = 1'b0;
      arst_n      = 1'b1;
      #1 arst_n   = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      #2 arst_n = 1'b1;
      #1;
      chk("ready_after_reset_p", 32'(rdy_p), 32'd1);
      chk("ready_after_reset_a", 32'(rdy_a), 32'd1);

      // pulse basic, then idle
      step(0, 1, 3'd2, 1);
      step(0, 0, 3'd0, 1);
      step(0, 0, 3'd0, 1);
      // back-pressure: 1 held, 3 refused until ready rises
      step(0, 1, 3'd1, 0);
      step(0, 1, 3'd3, 0);
      step(0, 1, 3'd3, 0);
      step(0, 1, 3'd3, 1);
      step(0, 0, 3'd0, 1);
      step(0, 0, 3'd0, 1);
      // streaming without bubbles
      for (int i = 0; i < 4; i++) step(0, 1, IW'(i), 1);
      step(0, 0, 3'd0, 1);
      // accumulate with clear, including repeated bit and clear+transfer
      step(1, 0, 3'd0, 1);
      step(0, 1, 3'd0, 1);
      step(0, 1, 3'd3, 1);
      step(0, 1, 3'd3, 1);
      step(1, 1, 3'd1, 1);
      step(0, 0, 3'd0, 1);
      // out-of-range then in-range top index
      step(0, 1, 3'd6, 1);
      step(0, 1, 3'd4, 1);
      step(0, 0, 3'd0, 1);
      step(0, 0, 3'd0, 1);
      step(1, 0, 3'd0, 1);
      // clear discarding a back-pressured update
      step(0, 1, 3'd7, 0);
      step(1, 0, 3'd0, 0);
      step(0, 0, 3'd0, 1);

      // randomized phases: varying ready, valid and clear densities
      for (int ph = 0; ph < 4; ph++) begin
         for (int c = 0; c < 500; c++) begin
            step($urandom_range(0, 99) < (ph * 3),
                 $urandom_range(0, 99) < (40 + ph * 15),
                 IW'($urandom_range(0, 7)),
                 $urandom_range(0, 99) < (90 - ph * 25));
         end
      end

      // asynchronous reset with an update pending under back-pressure
      step(0, 1, 3'd2, 0);
      step(0, 0, 3'd0, 0);
      @(posedge clk);
      #1;
      mon_en      = 1'b0;
      index_valid = 1'b0;
      clear       = 1'b0;
      #2 arst_n   = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      model_reset();
      @(posedge clk);
      #3 arst_n = 1'b1;
      #1;
      chk("ready_after_midreset", 32'(rdy_p & rdy_a), 32'd1);
      step(0, 1, 3'd4, 1);
      step(0, 1, 3'd5, 1);

      repeat (3) step(0, 0, 3'd0, 1);
      @(negedge clk);
      #1;
      chk("queue_left_pulse", 32'(qp.size()), 32'd0);
      chk("queue_left_accum", 32'(qa.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
